// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: datapath widths, ALU operation
// codes, forwarding select codes and the memory-stage control bundle.
package mips_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned ALU_CTRL_W = 3;
  localparam int unsigned OP_W       = 5;
  localparam int unsigned FWD_W      = 2;

  // ALU control codes; any other code yields result 0, no overflow.
  typedef enum logic [ALU_CTRL_W-1:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_e;

  // Operand source selects; 2'b11 is never generated and falls back to RF.
  typedef enum logic [FWD_W-1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  // Controls carried from EX into the memory stage.
  typedef struct packed {
    logic reg_write;
    logic mem2reg;
    logic mem_wr;
  } mem_ctrl_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU for the execute stage.
// Ports:
//   src_a, src_b  operands
//   alu_control   operation code (see mips_pkg::alu_op_e)
//   result        AND/OR/ADD/SUB/SLT result, 0 for unused codes
//   ovf           signed overflow of ADD/SUB, 0 otherwise
module alu_core
  import mips_pkg::*;
#(
  parameter int unsigned data_width     = DATA_W,
  parameter int unsigned alu_ctrl_width = ALU_CTRL_W
) (
  input  logic [data_width-1:0]     src_a,
  input  logic [data_width-1:0]     src_b,
  input  logic [alu_ctrl_width-1:0] alu_control,
  output logic [data_width-1:0]     result,
  output logic                      ovf
);

  localparam int unsigned MSB = data_width - 1;

  logic [data_width-1:0] w_sum;
  logic [data_width-1:0] w_diff;
  logic                  w_lt;

  assign w_sum  = src_a + src_b;
  assign w_diff = src_a - src_b;
  assign w_lt   = $signed(src_a) < $signed(src_b);

  // Operation select; overflow looks only at operand and result sign bits.
  always_comb begin
    result = '0;
    ovf    = 1'b0;
    case (alu_control)
      alu_ctrl_width'(ALU_AND): result = src_a & src_b;
      alu_ctrl_width'(ALU_OR):  result = src_a | src_b;
      alu_ctrl_width'(ALU_ADD): begin
        result = w_sum;
        ovf    = (src_a[MSB] == src_b[MSB]) && (w_sum[MSB] != src_a[MSB]);
      end
      alu_ctrl_width'(ALU_SUB): begin
        result = w_diff;
        ovf    = (src_a[MSB] != src_b[MSB]) && (w_diff[MSB] != src_a[MSB]);
      end
      alu_ctrl_width'(ALU_SLT): result = {{(data_width-1){1'b0}}, w_lt};
      default: begin
        result = '0;
        ovf    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/execute_stage.sv
// MIPS execute stage: MEM/WB operand forwarding, ALU, destination select and
// the EX/MEM pipeline register.
// Ports:
//   clk, reset                 clock, async active-high reset of EX/MEM
//   *_e                        ID/EX pipeline register contents
//   reg_write_w/write_reg_w/result_w  writeback-stage write port
//   write_reg_e, forward_ae/be combinational destination and forward selects
//   *_m, ovf_m                 EX/MEM pipeline register outputs
module execute_stage
  import mips_pkg::*;
#(
  parameter int unsigned data_width     = DATA_W,
  parameter int unsigned alu_ctrl_width = ALU_CTRL_W,
  parameter int unsigned op_width       = OP_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      reg_write_e,
  input  logic                      mem2reg_e,
  input  logic                      mem_wr_e,
  input  logic                      alu_src_e,
  input  logic                      reg_dst_e,
  input  logic [alu_ctrl_width-1:0] alu_control_e,
  input  logic [data_width-1:0]     rd1_e,
  input  logic [data_width-1:0]     rd2_e,
  input  logic [op_width-1:0]       rse,
  input  logic [op_width-1:0]       rte,
  input  logic [op_width-1:0]       rde,
  input  logic [data_width-1:0]     sign_extend_e,
  input  logic                      reg_write_w,
  input  logic [op_width-1:0]       write_reg_w,
  input  logic [data_width-1:0]     result_w,
  output logic [op_width-1:0]       write_reg_e,
  output logic [1:0]                forward_ae,
  output logic [1:0]                forward_be,
  output logic                      reg_write_m,
  output logic                      mem2reg_m,
  output logic                      mem_wr_m,
  output logic [data_width-1:0]     alu_out_m,
  output logic [data_width-1:0]     write_data_m,
  output logic [op_width-1:0]       write_reg_m,
  output logic                      ovf_m
);

  mem_ctrl_t             r_ctrl;
  logic [data_width-1:0] r_alu_out;
  logic [data_width-1:0] r_write_data;
  logic [op_width-1:0]   r_write_reg;
  logic                  r_ovf;

  logic [data_width-1:0] w_src_a;
  logic [data_width-1:0] w_fwd_b;
  logic [data_width-1:0] w_src_b;
  logic [data_width-1:0] w_alu_result;
  logic                  w_alu_ovf;
  logic                  w_mem_hit_a;
  logic                  w_mem_hit_b;
  logic                  w_wb_hit_a;
  logic                  w_wb_hit_b;

  assign write_reg_e = reg_dst_e ? rde : rte;

  // Register 0 is hardwired, so a write to it is never a forwarding source.
  assign w_mem_hit_a = r_ctrl.reg_write && (r_write_reg != '0) && (r_write_reg == rse);
  assign w_mem_hit_b = r_ctrl.reg_write && (r_write_reg != '0) && (r_write_reg == rte);
  assign w_wb_hit_a  = reg_write_w && (write_reg_w != '0) && (write_reg_w == rse);
  assign w_wb_hit_b  = reg_write_w && (write_reg_w != '0) && (write_reg_w == rte);

  // Forward selects: the younger MEM result wins over WB.
  always_comb begin
    forward_ae = FWD_RF;
    forward_be = FWD_RF;
    if (w_mem_hit_a)     forward_ae = FWD_MEM;
    else if (w_wb_hit_a) forward_ae = FWD_WB;
    if (w_mem_hit_b)     forward_be = FWD_MEM;
    else if (w_wb_hit_b) forward_be = FWD_WB;
  end

  // Operand muxes; the unused 2'b11 select falls back to register-file data.
  always_comb begin
    w_src_a = rd1_e;
    w_fwd_b = rd2_e;
    case (forward_ae)
      FWD_WB:  w_src_a = result_w;
      FWD_MEM: w_src_a = r_alu_out;
      default: w_src_a = rd1_e;
    endcase
    case (forward_be)
      FWD_WB:  w_fwd_b = result_w;
      FWD_MEM: w_fwd_b = r_alu_out;
      default: w_fwd_b = rd2_e;
    endcase
  end

  assign w_src_b = alu_src_e ? sign_extend_e : w_fwd_b;

  alu_core #(
    .data_width     (data_width),
    .alu_ctrl_width (alu_ctrl_width)
  ) u_alu (
    .src_a       (w_src_a),
    .src_b       (w_src_b),
    .alu_control (alu_control_e),
    .result      (w_alu_result),
    .ovf         (w_alu_ovf)
  );

  // EX/MEM pipeline register; store data is the forwarded B operand.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ctrl       <= '0;
      r_alu_out    <= '0;
      r_write_data <= '0;
      r_write_reg  <= '0;
      r_ovf        <= 1'b0;
    end else begin
      r_ctrl       <= '{reg_write: reg_write_e, mem2reg: mem2reg_e, mem_wr: mem_wr_e};
      r_alu_out    <= w_alu_result;
      r_write_data <= w_fwd_b;
      r_write_reg  <= write_reg_e;
      r_ovf        <= w_alu_ovf;
    end
  end

  assign reg_write_m  = r_ctrl.reg_write;
  assign mem2reg_m    = r_ctrl.mem2reg;
  assign mem_wr_m     = r_ctrl.mem_wr;
  assign alu_out_m    = r_alu_out;
  assign write_data_m = r_write_data;
  assign write_reg_m  = r_write_reg;
  assign ovf_m        = r_ovf;

endmodule
